// File: rtl/mmio_sim_ctrl.sv
// rtl/mmio_sim_ctrl.sv - MMIO simulation/debug controller: halt latch, cycle watchdog, byte-stream channels
module mmio_sim_ctrl #(
  parameter logic [31:0] BASE      = 32'hf0000000,
  parameter int          NCH       = 2,
  parameter int          DEPTH     = 16,
  parameter int          CYC_W     = 64,
  parameter int unsigned MAX_CYCLE = 100000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mmio_oe,
  input  logic [3:0]         mmio_we,
  input  logic [31:0]        mmio_addr,
  input  logic [31:0]        mmio_wdata,
  output logic [31:0]        mmio_rdata,
  output logic [NCH-1:0]     ch_valid,
  output logic [8*NCH-1:0]   ch_data,
  input  logic [NCH-1:0]     ch_ready,
  output logic               halt,
  output logic [31:0]        halt_code,
  output logic               abort,
  output logic [CYC_W-1:0]   cycle
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0]      r_rdata;
  logic             r_halt;
  logic [31:0]      r_halt_code;
  logic             r_abort;
  logic [CYC_W-1:0] r_cycle;
  logic [31:0]      r_limit;

  logic [31:0]      w_off;
  logic             w_wr;
  logic             w_rd;
  logic             w_run;
  logic             w_expire;
  logic [31:0]      w_halt_val;
  logic [31:0]      w_rval;
  logic [63:0]      w_cyc64;
  logic [NCH-1:0]   w_sel_ch;
  logic [31:0]      w_stat [NCH];

  assign w_off    = mmio_addr - BASE;
  assign w_wr     = mmio_oe & mmio_we[0];
  assign w_rd     = mmio_oe & ~mmio_we[0];
  assign w_run    = ~r_halt & ~r_abort;
  assign w_cyc64  = 64'(r_cycle);
  // Counter is held on the expiring cycle so it freezes at the first value above LIMIT.
  assign w_expire = (r_limit != 32'h0) && (r_cycle > {{(CYC_W-32){1'b0}}, r_limit});

  always_comb begin
    w_halt_val = '0;
    for (int b = 0; b < 4; b++)
      w_halt_val[8*b +: 8] = mmio_we[b] ? mmio_wdata[8*b +: 8] : 8'h00;
  end

  always_comb begin
    w_rval = '0;
    if (w_off == 32'h000)      w_rval = r_halt_code;
    else if (w_off == 32'h004) w_rval = w_cyc64[31:0];
    else if (w_off == 32'h008) w_rval = w_cyc64[63:32];
    else if (w_off == 32'h00c) w_rval = r_limit;
    for (int k = 0; k < NCH; k++)
      if (w_sel_ch[k]) w_rval = w_stat[k];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rdata     <= '0;
      r_halt      <= 1'b0;
      r_halt_code <= '0;
      r_abort     <= 1'b0;
      r_cycle     <= '0;
      r_limit     <= 32'(MAX_CYCLE);
    end else begin
      if (w_run && !w_expire) r_cycle <= r_cycle + CYC_W'(1);
      if (w_expire) r_abort <= 1'b1;
      if (w_wr && (w_off == 32'h000) && w_run) begin
        r_halt      <= 1'b1;
        r_halt_code <= w_halt_val;
      end
      if (w_wr && (w_off == 32'h00c)) r_limit <= mmio_wdata;
      if (w_rd) r_rdata <= w_rval;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [7:0]  r_mem [DEPTH];
    logic [AW:0] r_wp;
    logic [AW:0] r_rp;
    logic        r_ovf;
    logic [AW:0] w_cnt;
    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic        w_accept;

    assign w_sel_ch[k] = (w_off == 32'(256 * (k + 1)));
    assign w_cnt       = r_wp - r_rp;
    assign w_empty     = (r_wp == r_rp);
    assign w_full      = w_cnt[AW];
    assign w_pop       = ~w_empty & ch_ready[k];
    assign w_push      = w_wr & w_sel_ch[k];
    // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
    assign w_accept    = w_push & (~w_full | w_pop);
    assign w_stat[k]   = {16'h0, 8'(w_cnt), 5'h0, r_ovf, w_empty, ~w_full};

    assign ch_valid[k]         = ~w_empty;
    assign ch_data[8*k +: 8]   = r_mem[r_rp[AW-1:0]];

    always_ff @(posedge clk) begin
      if (!rst) begin
        r_wp  <= '0;
        r_rp  <= '0;
        r_ovf <= 1'b0;
      end else begin
        if (w_accept) r_wp <= r_wp + 1'b1;
        if (w_pop)    r_rp <= r_rp + 1'b1;
        // New overflow beats the clear-on-read of the same cycle.
        if (w_push && !w_accept)        r_ovf <= 1'b1;
        else if (w_rd && w_sel_ch[k])   r_ovf <= 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (w_accept) r_mem[r_wp[AW-1:0]] <= mmio_wdata[7:0];
    end
  end

  assign mmio_rdata = r_rdata;
  assign halt       = r_halt;
  assign halt_code  = r_halt_code;
  assign abort      = r_abort;
  assign cycle      = r_cycle;
endmodule

// File: doc/mmio_sim_ctrl.md
# mmio_sim_ctrl

Parametrised memory-mapped simulation/debug controller on the CPU's MMIO bus at `BASE`, alongside `mmio_oe`/`mmio_we` decode. It provides:

- a halt register that latches an exit code;
- a free-running cycle counter with a programmable watchdog limit;
- `NCH` independent byte-stream output channels, each buffered by a `DEPTH`-entry FIFO with valid/ready drain.

It is synthesizable, so the same console/halt protocol works on the board and under simulation.

## Interface
Parameters:
- `BASE`, 32'hf0000000, base address of the register window.
- `NCH`, 2, number of output channels (1..8).
- `DEPTH`, 16, FIFO entries per channel (power of 2, ≥2).
- `CYC_W`, 64, cycle counter width (33..64).
- `MAX_CYCLE`, 100000, reset value of the watchdog limit.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-low.
- `mmio_oe`  in  1  bus access strobe.
- `mmio_we`  in  4  byte write enables; access is a write iff `mmio_we[0]`.
- `mmio_addr`  in  32  byte address.
- `mmio_wdata`  in  32  write data.
- `mmio_rdata`  out  32  registered read data.
- `ch_valid`  out  NCH  channel k has a byte at head.
- `ch_data`  out  8*NCH  channel k head byte at `[8k+:8]`.
- `ch_ready`  in  NCH  sink accepts channel k byte.
- `halt`  out  1  sticky: program wrote HALT.
- `halt_code`  out  32  code written to HALT.
- `abort`  out  1  sticky: watchdog expired.
- `cycle`  out  CYC_W  current cycle count.

## Operation
Register map (offset from `BASE`):
- 0x000 HALT.
  - Write: `halt_code` gets `mmio_wdata` with unenabled byte lanes zeroed, and `halt` is set to 1.
  - Ignored once `halt` or `abort` is 1, so the first code wins.
  - Read: `halt_code`.
- 0x004 CYCLE_LO / 0x008 CYCLE_HI. Read-only. The high word is zero-extended above `CYC_W`.
- 0x00C LIMIT. Read/write, 32 bits, reset value `MAX_CYCLE`. A value of 0 disables the watchdog.
- 0x100·(k+1), k < NCH, CHk.
  - Write: push `mmio_wdata[7:0]`.
  - Read: status word.
    - bit0 = not full.
    - bit1 = empty.
    - bit2 = overflow (sticky; cleared by this read).
    - bits[15:8] = occupancy.
    - All other bits 0.
- Any other offset: writes are ignored and reads return 0.

Cycle counter:
- Starts at 0 after reset and increments by 1 each cycle while `halt`=0 and `abort`=0.
- Frozen once either is set.
- Wraps modulo 2^CYC_W.

Watchdog:
- `abort` is set on the cycle in which LIMIT≠0 and `cycle` > LIMIT (zero-extended).
- `abort` stays set until reset.

Channel FIFO:
- Show-ahead: `ch_data[k]` is the head byte whenever `ch_valid[k]`=1.
- Pop occurs when `ch_valid[k]` & `ch_ready[k]`.
- Push while full is dropped and sets overflow, except when a pop occurs in the same cycle; then the push is accepted.
- Push and pop in the same cycle leave occupancy unchanged.
- Read/write pointers use log2(DEPTH)+1 bits and wrap naturally.

Channels keep draining after `halt`/`abort`, so pending output is not lost. Pushes after `halt` are still accepted.

## Timing
- Reset (`rst`=0 at a clk edge) forces the following, regardless of in-flight accesses:
  - `mmio_rdata`=0, `halt`=0, `halt_code`=0, `abort`=0, `cycle`=0.
  - LIMIT=`MAX_CYCLE`.
  - All FIFOs empty, `ch_valid`=0, overflow=0.
  - `ch_data` is don't-care while `ch_valid`=0.
- Read latency 1:
  - `mmio_rdata` is valid the cycle after `mmio_oe`=1 with `mmio_we[0]`=0.
  - `mmio_rdata` holds its value otherwise.
  - A status read reflects state before that cycle's push/pop.
- Write effect 1 cycle:
  - `halt` rises the cycle after the HALT write.
  - `ch_valid` rises the cycle after a push into an empty FIFO.
  - A LIMIT write takes effect for the compare in the following cycle.
- Pop is a single-cycle handshake. Back-to-back pops drain one byte per cycle, and `ch_valid` falls the cycle after the last pop.
- Simultaneous status read and overflow-setting push: the read returns the old value and overflow ends set. The new event is not lost.

## Test plan
- Reset, then idle 10 cycles → `cycle`=10, `halt`=0, `abort`=0, `ch_valid`=0; read 0x00C → `MAX_CYCLE`.
- Write 0x41, 0x42 to BASE+0x100 with `ch_ready`=0, then raise `ch_ready` → `ch_data[7:0]`=0x41 then 0x42 on consecutive cycles, and `ch_valid[0]` drops after.
- Push DEPTH+1 bytes to CH1 with `ch_ready`=0 → status reads 0x1004 with DEPTH=16 (bit2 set, bit0 clear, count=16). A second read → 0x1000.
- Write LIMIT=20 and run → `abort` rises when `cycle`=21, and `cycle` freezes at 21.
- Write HALT with 0xdeadbeef and `mmio_we`=4'b0011 → `halt`=1, `halt_code`=0x0000beef. A later HALT write of 0x1 → code unchanged and `cycle` frozen.
- Assert `rst`=0 with CH0 half full and `halt`=1 → all outputs return to reset values the next cycle.
